// File: rtl/pixel_pkg.sv
// Shared definitions for the camera pixel packer.
// Pixel width, lane count, frame size default and FSM states.
package pixel_pkg;

    localparam int PIX_W       = 16;
    localparam int LANES       = 128 / PIX_W;
    localparam int FRAME_WORDS = 14_400;

    typedef enum logic {
        IDLE,
        PACK
    } packer_state_t;

endpackage

// File: rtl/evt_counter.sv
// Event counter that wraps at MAX_COUNT-1.
// Ports: clk, rst (async), clr (sync restart), inc, count, at_max.
module evt_counter #(
    parameter int MAX_COUNT = 14_400,
    parameter int CW        = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          at_max
);

    assign at_max = (count == CW'(MAX_COUNT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= at_max ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/pixel_packer.sv
// Packs camera pixels into 128-bit AXI-Stream words with frame TLAST.
// Ports: clk_in, rst_in, pixel_valid/data, frame_start, m_axis_*, overflow, resync.
module pixel_packer
    import pixel_pkg::*;
#(
    parameter int FRAME_WORDS = pixel_pkg::FRAME_WORDS,
    parameter int PIX_W       = pixel_pkg::PIX_W
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             pixel_valid,
    input  logic [PIX_W-1:0] pixel_data,
    input  logic             frame_start,
    output logic [127:0]     m_axis_data,
    output logic             m_axis_tlast,
    output logic             m_axis_valid,
    input  logic             m_axis_ready,
    output logic             overflow,
    output logic             resync
);

    localparam int NL     = 128 / PIX_W;
    localparam int LANE_W = $clog2(NL);
    localparam int CW     = $clog2(FRAME_WORDS > 1 ? FRAME_WORDS : 2);

    packer_state_t     state;
    logic [LANE_W-1:0] lane;
    logic [127:0]      acc;

    logic [127:0] word_ins;
    logic [127:0] fresh;
    logic         start_px;
    logic         early;
    logic         last_lane;
    logic         word_done;
    logic         enq;
    logic [127:0] enq_data;
    logic         enq_last;
    logic         restart;

    logic [CW-1:0] word_count;
    logic          at_max;

    // The accumulator is cleared after every word, so lanes not yet
    // written are already zero when an early frame forces a flush.
    always_comb begin
        word_ins = acc;
        word_ins[lane*PIX_W +: PIX_W] = pixel_data;
        fresh = '0;
        fresh[PIX_W-1:0] = pixel_data;
    end

    assign start_px  = pixel_valid && frame_start;
    assign early     = (state == PACK) && start_px;
    assign last_lane = (lane == LANE_W'(NL - 1));
    assign word_done = (state == PACK) && pixel_valid
                     && !frame_start && last_lane;
    assign enq       = early || word_done;
    assign enq_data  = early ? acc : word_ins;
    assign enq_last  = early ? 1'b1 : at_max;
    assign restart   = start_px || (word_done && at_max);

    // Dropped words still count, keeping TLAST on the right index.
    evt_counter #(
        .MAX_COUNT (FRAME_WORDS),
        .CW        (CW)
    ) u_word_cnt (
        .clk    (clk_in),
        .rst    (rst_in),
        .clr    (restart),
        .inc    (word_done),
        .count  (word_count),
        .at_max (at_max)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state  <= IDLE;
            lane   <= '0;
            acc    <= '0;
            resync <= 1'b0;
        end else begin
            resync <= early;
            unique case (state)
                IDLE: begin
                    if (start_px) begin
                        acc   <= fresh;
                        lane  <= LANE_W'(1);
                        state <= PACK;
                    end
                end
                PACK: begin
                    if (start_px) begin
                        acc  <= fresh;
                        lane <= LANE_W'(1);
                    end else if (pixel_valid) begin
                        if (last_lane) begin
                            acc  <= '0;
                            lane <= '0;
                            if (at_max) begin
                                state <= IDLE;
                            end
                        end else begin
                            acc  <= word_ins;
                            lane <= lane + LANE_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Two-entry output FIFO, entry = {tlast, data}.
    logic [128:0] mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   fill;
    logic [1:0]   fill_nx;
    logic         full;
    logic         deq;
    logic         push;
    logic         drop;

    assign full = (fill == 2'd2);
    assign deq  = m_axis_valid && m_axis_ready;
    // When full, a same-cycle dequeue frees the slot being written.
    assign push = enq && (!full || deq);
    assign drop = enq && full && !deq;

    always_comb begin
        fill_nx = fill;
        if (push && !deq) begin
            fill_nx = fill + 2'd1;
        end else if (deq && !push) begin
            fill_nx = fill - 2'd1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mem[0]   <= '0;
            mem[1]   <= '0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            fill     <= 2'd0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {enq_last, enq_data};
                wr_ptr      <= ~wr_ptr;
            end
            if (deq) begin
                rd_ptr <= ~rd_ptr;
            end
            fill <= fill_nx;
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    assign m_axis_valid = (fill != 2'd0);
    assign m_axis_tlast = mem[rd_ptr][128];
    assign m_axis_data  = mem[rd_ptr][127:0];

endmodule
